// File: rtl/bus_defs.sv
// Shared bus definitions: state encoding and default widths
// used by the master output port and the slave-side ports.
package bus_defs;

   localparam int ADDR_W_DEF     = 12;
   localparam int DATA_W_DEF     = 8;
   localparam int LEN_W_DEF      = 4;
   localparam int HS_TIMEOUT_DEF = 64;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_HANDSHAKE = 3'd1,
      ST_ADDR      = 3'd2,
      ST_DATA_WAIT = 3'd3,
      ST_DATA      = 3'd4,
      ST_DONE      = 3'd5,
      ST_ABORT     = 3'd6
   } bus_state_t;

endpackage

// File: rtl/serial_shifter.sv
// LSB-first parallel-to-serial shifter with a registered serial output.
// Ports: clk, reset (sync, high), load/data (parallel word), shift
// (emit one bit this edge), lsb (registered serial bit), done (WIDTH
// bits emitted since the last load).
module serial_shifter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] data,
   input  logic             shift,
   output logic             lsb,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] src;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_base;

   // Load and shift may coincide: the first bit of a freshly loaded
   // word goes out on the same edge it is captured.
   always_comb begin
      src      = load ? data : sreg;
      cnt_base = load ? '0 : cnt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sreg <= '0;
         cnt  <= '0;
         lsb  <= 1'b0;
      end else if (shift) begin
         lsb  <= src[0];
         sreg <= src >> 1;
         cnt  <= cnt_base + 1'b1;
      end else begin
         // Serial line idles low between words.
         lsb <= 1'b0;
         if (load) begin
            sreg <= data;
            cnt  <= '0;
         end
      end
   end

   assign done = (cnt == CW'(WIDTH));

endmodule

// File: rtl/master_out_port.sv
// Master-side serialiser: handshakes with the slave, then shifts the
// address and write bytes LSB-first onto tx_address / tx_data.
// Ports: req_* (core request, accepted in IDLE), wdata/wdata_valid/
// wdata_ready (per-beat write byte), slave_ready/master_valid (bus
// handshake), read_en/write_en/tx_burst (transaction qualifiers),
// tx_address/tx_data (serial lines), tx_done/tx_abort (end pulses).
module master_out_port
   import bus_defs::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int LEN_W      = LEN_W_DEF,
   parameter int HS_TIMEOUT = HS_TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic              req_burst,
   input  logic [LEN_W-1:0]  req_len,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              wdata_valid,
   output logic              wdata_ready,
   input  logic              slave_ready,
   output logic              master_valid,
   output logic              read_en,
   output logic              write_en,
   output logic              tx_address,
   output logic              tx_data,
   output logic              tx_burst,
   output logic              tx_done,
   output logic              tx_abort
);

   localparam int TW = $clog2(HS_TIMEOUT + 1);

   typedef struct packed {
      logic             write;
      logic             burst;
      logic [LEN_W-1:0] beats;
   } req_t;

   bus_state_t state;
   bus_state_t state_nx;

   req_t          req_q;
   logic [TW-1:0] hs_cnt;

   logic accept;
   logic write_nx;
   logic burst_nx;
   logic bus_nx;
   logic addr_shift;
   logic addr_done;
   logic data_shift;
   logic data_done;
   logic last_beat;

   assign req_ready   = (state == ST_IDLE);
   assign accept      = req_valid & req_ready;
   assign wdata_ready = (state == ST_DATA_WAIT) & wdata_valid;
   assign last_beat   = (req_q.beats == '0);

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE: begin
            if (req_valid) state_nx = ST_HANDSHAKE;
         end
         ST_HANDSHAKE: begin
            // A ready slave on the final timer cycle still wins.
            if (slave_ready)
               state_nx = ST_ADDR;
            else if (hs_cnt == TW'(HS_TIMEOUT - 1))
               state_nx = ST_ABORT;
         end
         ST_ADDR: begin
            if (addr_done)
               state_nx = req_q.write ? ST_DATA_WAIT : ST_DONE;
         end
         ST_DATA_WAIT: begin
            if (wdata_valid) state_nx = ST_DATA;
         end
         ST_DATA: begin
            if (data_done)
               state_nx = last_beat ? ST_DONE : ST_DATA_WAIT;
         end
         ST_DONE:  state_nx = ST_IDLE;
         ST_ABORT: state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state, so the request fields
   // must be seen on the accept edge before they are latched.
   always_comb begin
      write_nx   = accept ? req_write : req_q.write;
      burst_nx   = accept ? req_burst : req_q.burst;
      addr_shift = (state_nx == ST_ADDR);
      data_shift = (state_nx == ST_DATA);
      bus_nx     = 1'b0;
      unique case (1'b1)
         (state_nx == ST_HANDSHAKE): bus_nx = 1'b1;
         (state_nx == ST_ADDR):      bus_nx = 1'b1;
         (state_nx == ST_DATA_WAIT): bus_nx = 1'b1;
         (state_nx == ST_DATA):      bus_nx = 1'b1;
         default:                    bus_nx = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         req_q        <= '0;
         hs_cnt       <= '0;
         master_valid <= 1'b0;
         read_en      <= 1'b0;
         write_en     <= 1'b0;
         tx_burst     <= 1'b0;
         tx_done      <= 1'b0;
         tx_abort     <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            req_q.write <= req_write;
            req_q.burst <= req_burst;
            req_q.beats <= req_burst ? req_len : '0;
         end else if (state == ST_DATA && data_done && !last_beat) begin
            req_q.beats <= req_q.beats - 1'b1;
         end
         hs_cnt       <= (state == ST_HANDSHAKE) ? hs_cnt + 1'b1 : '0;
         master_valid <= bus_nx;
         read_en      <= bus_nx & ~write_nx;
         write_en     <= bus_nx & write_nx;
         tx_burst     <= bus_nx & burst_nx;
         tx_done      <= (state_nx == ST_DONE);
         tx_abort     <= (state_nx == ST_ABORT);
      end
   end

   serial_shifter #(
      .WIDTH (ADDR_W)
   ) u_addr_sh (
      .clk   (clk),
      .reset (reset),
      .load  (accept),
      .data  (req_addr),
      .shift (addr_shift),
      .lsb   (tx_address),
      .done  (addr_done)
   );

   serial_shifter #(
      .WIDTH (DATA_W)
   ) u_data_sh (
      .clk   (clk),
      .reset (reset),
      .load  (wdata_ready),
      .data  (wdata),
      .shift (data_shift),
      .lsb   (tx_data),
      .done  (data_done)
   );

endmodule

// File: tb/tb_master_out_port.sv
// Directed bench for master_out_port: a phase-level transaction model
// builds per-cycle stimulus and expected outputs, checked each cycle.
module tb_master_out_port;

   localparam int ADDR_W     = 12;
   localparam int DATA_W     = 8;
   localparam int LEN_W      = 4;
   localparam int HS_TIMEOUT = 64;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_write = 1'b0;
   logic              req_burst = 1'b0;
   logic [LEN_W-1:0]  req_len = '0;
   logic [ADDR_W-1:0] req_addr = '0;
   logic [DATA_W-1:0] wdata = '0;
   logic              wdata_valid = 1'b0;
   logic              wdata_ready;
   logic              slave_ready = 1'b0;
   logic              master_valid;
   logic              read_en;
   logic              write_en;
   logic              tx_address;
   logic              tx_data;
   logic              tx_burst;
   logic              tx_done;
   logic              tx_abort;

   always #5 clk = ~clk;

   master_out_port #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .LEN_W      (LEN_W),
      .HS_TIMEOUT (HS_TIMEOUT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_burst    (req_burst),
      .req_len      (req_len),
      .req_addr     (req_addr),
      .wdata        (wdata),
      .wdata_valid  (wdata_valid),
      .wdata_ready  (wdata_ready),
      .slave_ready  (slave_ready),
      .master_valid (master_valid),
      .read_en      (read_en),
      .write_en     (write_en),
      .tx_address   (tx_address),
      .tx_data      (tx_data),
      .tx_burst     (tx_burst),
      .tx_done      (tx_done),
      .tx_abort     (tx_abort)
   );

   typedef struct packed {
      logic              rst;
      logic              rv;
      logic              wr;
      logic              bu;
      logic [LEN_W-1:0]  len;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wd;
      logic              wv;
      logic              sr;
   } stim_t;

   typedef struct packed {
      logic req_ready;
      logic wdata_ready;
      logic master_valid;
      logic read_en;
      logic write_en;
      logic tx_address;
      logic tx_data;
      logic tx_burst;
      logic tx_done;
      logic tx_abort;
   } out_t;

   stim_t             stim_q[$];
   out_t              exp_q[$];
   logic [DATA_W-1:0] byte_tab[16];
   int                stall_tab[16];
   int                vectors = 0;
   int                miscompares = 0;
   int                cyc = 0;

   task automatic check(input string name, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic add(input stim_t s, input out_t o);
      stim_q.push_back(s);
      exp_q.push_back(o);
   endtask

   function automatic out_t idle_o();
      out_t o;
      o = '0;
      o.req_ready = 1'b1;
      return o;
   endfunction

   task automatic idle(input int n);
      stim_t s;
      s = '0;
      for (int i = 0; i < n; i++) add(s, idle_o());
   endtask

   // One transaction as a list of phases: accept, handshake,
   // address bits, per beat (stalls, take, data bits), done/abort.
   task automatic build(input logic wr, input logic bu,
                        input logic [LEN_W-1:0] len,
                        input logic [ADDR_W-1:0] addr,
                        input logic sr, input logic hold);
      stim_t s;
      out_t  ob;
      out_t  o;
      int    beats;
      s      = '0;
      s.wr   = wr;
      s.bu   = bu;
      s.len  = len;
      s.addr = addr;
      s.sr   = sr;
      s.rv   = 1'b1;
      add(s, idle_o());
      s.rv = hold;
      ob = '0;
      ob.master_valid = 1'b1;
      ob.read_en      = ~wr;
      ob.write_en     = wr;
      ob.tx_burst     = bu;
      if (!sr) begin
         for (int i = 0; i < HS_TIMEOUT; i++) add(s, ob);
         o = '0;
         o.tx_abort = 1'b1;
         add(s, o);
         return;
      end
      add(s, ob);
      s.sr = 1'b0;
      for (int k = 0; k < ADDR_W; k++) begin
         o = ob;
         o.tx_address = addr[k];
         add(s, o);
      end
      if (wr) begin
         beats = bu ? int'(len) + 1 : 1;
         for (int b = 0; b < beats; b++) begin
            for (int i = 0; i < stall_tab[b]; i++) add(s, ob);
            s.wv = 1'b1;
            s.wd = byte_tab[b];
            o = ob;
            o.wdata_ready = 1'b1;
            add(s, o);
            s.wv = 1'b0;
            for (int k = 0; k < DATA_W; k++) begin
               o = ob;
               o.tx_data = byte_tab[b][k];
               add(s, o);
            end
         end
      end
      o = '0;
      o.tx_done = 1'b1;
      add(s, o);
   endtask

   function automatic int find_end(input int t0);
      for (int i = t0; i < exp_q.size(); i++)
         if (exp_q[i].tx_done || exp_q[i].tx_abort) return i - t0;
      return -1;
   endfunction

   task automatic run();
      stim_t s;
      out_t  e;
      out_t  a;
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         e = exp_q.pop_front();
         @(posedge clk);
         #1;
         reset       = s.rst;
         req_valid   = s.rv;
         req_write   = s.wr;
         req_burst   = s.bu;
         req_len     = s.len;
         req_addr    = s.addr;
         wdata       = s.wd;
         wdata_valid = s.wv;
         slave_ready = s.sr;
         @(negedge clk);
         a = {req_ready, wdata_ready, master_valid, read_en,
              write_en, tx_address, tx_data, tx_burst,
              tx_done, tx_abort};
         vectors++;
         if (a !== e) begin
            miscompares++;
            $display("FAIL cycle %0d outputs: got %b expected %b",
                     cyc, a, e);
         end
         cyc++;
      end
   endtask

   initial begin
      stim_t             s;
      int                t0;
      int                n;
      logic [ADDR_W-1:0] abits;
      logic [DATA_W-1:0] dbits;
      logic [ADDR_W-1:0] lit_a;
      logic [DATA_W-1:0] lit_d;

      for (int i = 0; i < 16; i++) begin
         byte_tab[i]  = '0;
         stall_tab[i] = 0;
      end

      s = '0;
      s.rst = 1'b1;
      add(s, idle_o());
      add(s, idle_o());
      idle(2);
      run();

      // Single write 0xA5C / 0x3B
      byte_tab[0] = 8'h3B;
      t0 = exp_q.size();
      build(1'b1, 1'b0, 4'd0, 12'hA5C, 1'b1, 1'b0);
      for (int k = 0; k < ADDR_W; k++)
         abits[k] = exp_q[t0 + 2 + k].tx_address;
      for (int k = 0; k < DATA_W; k++)
         dbits[k] = exp_q[t0 + 15 + k].tx_data;
      lit_a = 12'b1010_0101_1100;
      lit_d = 8'b0011_1011;
      check("wr_addr_bits", int'(abits), int'(lit_a));
      check("wr_data_bits", int'(dbits), int'(lit_d));
      check("wr_done_cycle", find_end(t0), 23);
      check("wr_take_cycle", int'(exp_q[t0 + 14].wdata_ready), 1);
      idle(2);
      run();

      // Single read 0x001
      t0 = exp_q.size();
      build(1'b0, 1'b0, 4'd0, 12'h001, 1'b1, 1'b0);
      check("rd_done_cycle", find_end(t0), 14);
      n = 0;
      for (int i = t0; i < exp_q.size(); i++)
         n += int'(exp_q[i].write_en);
      check("rd_write_en", n, 0);
      idle(2);
      run();

      // Burst write len=2, no stall then 5-cycle stall on 2nd byte
      byte_tab[0] = 8'h01;
      byte_tab[1] = 8'h02;
      byte_tab[2] = 8'h03;
      t0 = exp_q.size();
      build(1'b1, 1'b1, 4'd2, 12'h3F0, 1'b1, 1'b0);
      check("burst_len", find_end(t0) + 1, 42);
      idle(1);
      run();
      stall_tab[1] = 5;
      t0 = exp_q.size();
      build(1'b1, 1'b1, 4'd2, 12'h3F0, 1'b1, 1'b0);
      check("burst_stall_len", find_end(t0) + 1, 47);
      n = 0;
      for (int i = t0; i < exp_q.size(); i++)
         n += int'(exp_q[i].wdata_ready);
      check("burst_takes", n, 3);
      idle(2);
      run();
      stall_tab[1] = 0;

      // Burst with len=0 and a burst read
      byte_tab[0] = 8'hE7;
      build(1'b1, 1'b1, 4'd0, 12'h800, 1'b1, 1'b0);
      build(1'b0, 1'b1, 4'd5, 12'h7FF, 1'b1, 1'b0);
      idle(2);
      run();

      // Handshake timeout
      t0 = exp_q.size();
      build(1'b1, 1'b0, 4'd0, 12'h555, 1'b0, 1'b0);
      check("abort_cycle", find_end(t0), 1 + HS_TIMEOUT);
      idle(2);
      run();

      // Reset in the middle of the data phase, then a fresh read
      byte_tab[0] = 8'hC6;
      t0 = exp_q.size();
      build(1'b1, 1'b0, 4'd0, 12'h123, 1'b1, 1'b0);
      while (exp_q.size() > t0 + 19) begin
         void'(exp_q.pop_back());
         void'(stim_q.pop_back());
      end
      s = stim_q.pop_back();
      s.rst = 1'b1;
      stim_q.push_back(s);
      idle(1);
      build(1'b0, 1'b0, 4'd0, 12'h0F0, 1'b1, 1'b0);
      idle(2);
      run();

      // req_valid held through a write; next request right after
      byte_tab[0] = 8'h5A;
      t0 = exp_q.size();
      build(1'b1, 1'b0, 4'd0, 12'hABC, 1'b1, 1'b1);
      check("hold_done_cycle", find_end(t0), 23);
      build(1'b0, 1'b1, 4'd1, 12'h00F, 1'b1, 1'b0);
      idle(3);
      run();

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
